// File: rtl/program_loader_if.sv
// Loader bundle: byte stream in, start pulse, program-memory write port and CPU control/status.
// master = stream/host side, slave = the loader itself.
interface program_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        start;
  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        load_active;
  logic        cpu_reset;
  logic        done;
  logic        overflow;

  modport master (
    output byte_in, byte_valid, start,
    input  byte_ready, mem_address, mem_data, mem_we, load_active, cpu_reset, done, overflow
  );

  modport slave (
    input  byte_in, byte_valid, start,
    output byte_ready, mem_address, mem_data, mem_we, load_active, cpu_reset, done, overflow
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: packs a length-prefixed big-endian byte stream into 32-bit words, writes them
// from BASE_ADDR upward, then releases the memory port and, RELEASE_DELAY cycles later, the CPU.
module program_loader #(
  parameter logic [15:0] BASE_ADDR     = 16'h0000,
  parameter int          RELEASE_DELAY = 4
) (
  input  logic             clock,
  input  logic             reset,
  program_loader_if.slave  bus
);

  localparam int RW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    RELEASE,
    DONE
  } state_t;

  state_t        state;
  logic [15:0]   n_words;
  logic [15:0]   idx;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_reg;
  logic [RW-1:0] rel_cnt;
  logic          take;
  logic          last_word;

  assign bus.byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign take           = bus.byte_valid & bus.byte_ready;
  assign last_word      = (16'(idx + 16'd1) == n_words);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= LEN_HI;
      n_words         <= 16'h0000;
      idx             <= 16'h0000;
      byte_cnt        <= 2'd0;
      word_reg        <= 24'h000000;
      rel_cnt         <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_address <= BASE_ADDR;
      bus.mem_data    <= 32'h0000_0000;
      bus.load_active <= 1'b1;
      bus.cpu_reset   <= 1'b1;
      bus.done        <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        LEN_HI: begin
          if (take) begin
            n_words[15:8] <= bus.byte_in;
            state         <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (take) begin
            n_words[7:0] <= bus.byte_in;
            if ({n_words[15:8], bus.byte_in} == 16'h0000) begin
              state           <= RELEASE;
              bus.load_active <= 1'b0;
              rel_cnt         <= '0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          // The 4th byte goes straight into mem_data so mem_we rises the cycle after it lands.
          if (take) begin
            if (byte_cnt == 2'd3) begin
              bus.mem_we      <= 1'b1;
              bus.mem_data    <= {word_reg, bus.byte_in};
              bus.mem_address <= BASE_ADDR + idx;
              byte_cnt        <= 2'd0;
              state           <= WRITE;
            end else begin
              word_reg <= {word_reg[15:0], bus.byte_in};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        WRITE: begin
          bus.mem_we <= 1'b0;
          idx        <= idx + 16'd1;
          if (last_word) begin
            state           <= RELEASE;
            bus.load_active <= 1'b0;
            rel_cnt         <= '0;
          end else begin
            state <= DATA;
            if (bus.mem_address == 16'hFFFF) begin
              bus.overflow <= 1'b1;
            end
          end
        end

        RELEASE: begin
          if (rel_cnt == RW'(RELEASE_DELAY - 1)) begin
            state         <= DONE;
            bus.cpu_reset <= 1'b0;
            bus.done      <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end

        DONE: begin
          if (bus.start) begin
            state           <= LEN_HI;
            bus.cpu_reset   <= 1'b1;
            bus.load_active <= 1'b1;
            bus.done        <= 1'b0;
            bus.overflow    <= 1'b0;
            idx             <= 16'h0000;
            byte_cnt        <= 2'd0;
          end
        end

        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (BASE 0000 and FFFF) run in lockstep on one stream.
module tb_program_loader;

  localparam int D = 4;

  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   cyc;
  int   wr_count;
  int   bad_we;
  int   mark;

  program_loader_if bus ();
  program_loader_if bus2 ();

  assign bus2.byte_in    = bus.byte_in;
  assign bus2.byte_valid = bus.byte_valid;
  assign bus2.start      = bus.start;

  program_loader #(.BASE_ADDR(16'h0000), .RELEASE_DELAY(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  program_loader #(.BASE_ADDR(16'hFFFF), .RELEASE_DELAY(D)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.mem_we) wr_count <= wr_count + 1;
    if (bus.mem_we && !bus.load_active) bad_we <= bad_we + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    t = 0;
    while (!bus.byte_ready && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    check("byte_ready_wait", {31'd0, bus.byte_ready}, 32'd1);
    @(posedge clock); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_cpu_run();
    int t;
    t = 0;
    while (bus.cpu_reset && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; wr_count = 0; bad_we = 0; mark = 0;
    reset = 1'b0;
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.start = 1'b0;

    #12;
    check("rst_addr",    {16'd0, bus.mem_address}, 32'h0000);
    check("rst_addr2",   {16'd0, bus2.mem_address}, 32'hFFFF);
    check("rst_data",    bus.mem_data, 32'h0);
    check("rst_we",      {31'd0, bus.mem_we}, 32'd0);
    check("rst_active",  {31'd0, bus.load_active}, 32'd1);
    check("rst_cpu",     {31'd0, bus.cpu_reset}, 32'd1);
    check("rst_done",    {31'd0, bus.done}, 32'd0);
    check("rst_ovf",     {31'd0, bus.overflow}, 32'd0);
    check("rst_ready",   {31'd0, bus.byte_ready}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;

    // Two words; BASE=FFFF instance wraps FFFF -> 0000
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    check("t1_we0",    {31'd0, bus.mem_we}, 32'd1);
    check("t1_addr0",  {16'd0, bus.mem_address}, 32'h0000);
    check("t1_data0",  bus.mem_data, 32'h40000005);
    check("t1_addr0b", {16'd0, bus2.mem_address}, 32'hFFFF);
    @(posedge clock); #1;
    check("t1_we_drop", {31'd0, bus.mem_we}, 32'd0);
    check("t1_addr_hold", {16'd0, bus.mem_address}, 32'h0000);
    send_byte(8'h70); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    mark = cyc;
    check("t1_we1",    {31'd0, bus.mem_we}, 32'd1);
    check("t1_addr1",  {16'd0, bus.mem_address}, 32'h0001);
    check("t1_data1",  bus.mem_data, 32'h70000010);
    check("t1_addr1b", {16'd0, bus2.mem_address}, 32'h0000);
    @(posedge clock); #1;
    check("t1_rel_active", {31'd0, bus.load_active}, 32'd0);
    check("t1_rel_cpu",    {31'd0, bus.cpu_reset}, 32'd1);
    check("t1_rel_ready",  {31'd0, bus.byte_ready}, 32'd0);
    wait_cpu_run();
    // WRITE cycle index + 1 (end of WRITE) + D release cycles
    check("t1_release_lat", cyc - mark, D + 1);
    check("t1_done",     {31'd0, bus.done}, 32'd1);
    check("t1_ovf_base0", {31'd0, bus.overflow}, 32'd0);
    check("t1_ovf_wrap", {31'd0, bus2.overflow}, 32'd1);
    check("t1_wr_count", wr_count, 2);
    repeat (3) @(posedge clock);
    #1;
    check("t1_ovf_sticky", {31'd0, bus2.overflow}, 32'd1);

    // Restart, then N=0
    pulse_start();
    check("st_cpu",    {31'd0, bus.cpu_reset}, 32'd1);
    check("st_active", {31'd0, bus.load_active}, 32'd1);
    check("st_done",   {31'd0, bus.done}, 32'd0);
    check("st_ovf_clr", {31'd0, bus2.overflow}, 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    mark = cyc;
    check("t2_active", {31'd0, bus.load_active}, 32'd0);
    check("t2_cpu",    {31'd0, bus.cpu_reset}, 32'd1);
    wait_cpu_run();
    check("t2_release_lat", cyc - mark, D);
    check("t2_done",     {31'd0, bus.done}, 32'd1);
    check("t2_no_write", wr_count, 2);
    check("t2_done_ready", {31'd0, bus.byte_ready}, 32'd0);

    // N=1 with byte_valid toggled every cycle
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hDEADBEEF;
      bus.byte_in    = w[31-8*i -: 8];
      bus.byte_valid = 1'b1;
      @(posedge clock); #1;
      bus.byte_valid = 1'b0;
      if (i < 3) begin
        check("t3_ready_hold", {31'd0, bus.byte_ready}, 32'd1);
        @(posedge clock); #1;
      end
    end
    check("t3_we",   {31'd0, bus.mem_we}, 32'd1);
    check("t3_addr", {16'd0, bus.mem_address}, 32'h0000);
    check("t3_data", bus.mem_data, 32'hDEADBEEF);
    wait_cpu_run();
    check("t3_done", {31'd0, bus.done}, 32'd1);

    // Reset after 3 of 4 data bytes, then a fresh load
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    reset = 1'b0;
    #2;
    check("t4_rst_data",   bus.mem_data, 32'h0);
    check("t4_rst_addr",   {16'd0, bus.mem_address}, 32'h0000);
    check("t4_rst_cpu",    {31'd0, bus.cpu_reset}, 32'd1);
    check("t4_rst_active", {31'd0, bus.load_active}, 32'd1);
    check("t4_rst_we",     {31'd0, bus.mem_we}, 32'd0);
    check("t4_rst_done",   {31'd0, bus.done}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33);
    check("t4_no_stale_we", {31'd0, bus.mem_we}, 32'd0);
    send_byte(8'h44);
    check("t4_we",   {31'd0, bus.mem_we}, 32'd1);
    check("t4_addr", {16'd0, bus.mem_address}, 32'h0000);
    check("t4_data", bus.mem_data, 32'h11223344);
    wait_cpu_run();
    check("t4_done", {31'd0, bus.done}, 32'd1);

    // Restart from DONE with one word
    pulse_start();
    check("t5_cpu",    {31'd0, bus.cpu_reset}, 32'd1);
    check("t5_active", {31'd0, bus.load_active}, 32'd1);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check("t5_we",   {31'd0, bus.mem_we}, 32'd1);
    check("t5_addr", {16'd0, bus.mem_address}, 32'h0000);
    check("t5_data", bus.mem_data, 32'h12345678);
    wait_cpu_run();
    check("t5_done",   {31'd0, bus.done}, 32'd1);
    check("t5_active_rel", {31'd0, bus.load_active}, 32'd0);

    @(posedge clock); #1;
    check("total_writes", wr_count, 5);
    check("we_without_ownership", bad_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
